// File: rtl/hazard_controller.sv
// hazard_controller
//   Pipeline hazard and sequencing controller for the 5-stage core.
//   - Forwarding selects for the Execute operands (Memory has priority over Writeback).
//   - Load-use detection between Execute and Decode.
//   - IDLE/BUSY multi-cycle FSM that holds Execute for MC_LATENCY cycles and
//     bubbles Memory while it waits.
//
//   Parameters: MC_LATENCY (1..16) cycles a multi-cycle op occupies Execute,
//               CNT_W width of the multi-cycle down-counter.
//   Inputs : clk, reset (async, active-high), Rs1D/Rs2D, Rs1E/Rs2E, RdE/RdM/RdW,
//            MemReadE, RegWriteM, RegWriteW, PCSrcE, MultiCycleE
//   Outputs: StallF/StallD/StallE, FlushD/FlushE/FlushM,
//            ForwardAE/ForwardBE (00 RF, 01 ResultW, 10 ALUResultM), BusyE
//   Optional: define HAZ_PERF_CNT_EN to add LwStallCnt, McStallCnt, FlushCnt
//             (32-bit wrapping cycle counters of lwStall, mcStall, PCSrcE).
module hazard_controller #(
   parameter int MC_LATENCY = 4,
   parameter int CNT_W      = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] Rs1D,
   input  logic [4:0] Rs2D,
   input  logic [4:0] Rs1E,
   input  logic [4:0] Rs2E,
   input  logic [4:0] RdE,
   input  logic [4:0] RdM,
   input  logic [4:0] RdW,
   input  logic       MemReadE,
   input  logic       RegWriteM,
   input  logic       RegWriteW,
   input  logic       PCSrcE,
   input  logic       MultiCycleE,
   output logic       StallF,
   output logic       StallD,
   output logic       StallE,
   output logic       FlushD,
   output logic       FlushE,
   output logic       FlushM,
   output logic [1:0] ForwardAE,
   output logic [1:0] ForwardBE,
   output logic       BusyE
`ifdef HAZ_PERF_CNT_EN
   ,
   output logic [31:0] LwStallCnt,
   output logic [31:0] McStallCnt,
   output logic [31:0] FlushCnt
`endif
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   // With MC_LATENCY==1 the op completes in one cycle and the FSM never leaves IDLE.
   localparam logic             MC_EN    = (MC_LATENCY >= 2);
   localparam int               MC_LOAD  = (MC_LATENCY >= 2) ? (MC_LATENCY - 2) : 0;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MC_LOAD);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             lw_stall;
   logic             mc_stall;

   function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
      logic [1:0] sel;
      sel = 2'b00;
      if (RegWriteM && (RdM != '0) && (RdM == rs))
         sel = 2'b10;
      else if (RegWriteW && (RdW != '0) && (RdW == rs))
         sel = 2'b01;
      return sel;
   endfunction

   always_comb begin
      lw_stall = MemReadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
      mc_stall = 1'b0;
      case (state)
         IDLE:    mc_stall = MC_EN && MultiCycleE;
         BUSY:    mc_stall = (cnt != '0);   // counter==0 is the release cycle
         default: mc_stall = 1'b0;
      endcase
   end

   // Outputs are forced inactive for as long as reset is held.
   always_comb begin
      StallF    = 1'b0;
      StallD    = 1'b0;
      StallE    = 1'b0;
      FlushD    = 1'b0;
      FlushE    = 1'b0;
      FlushM    = 1'b0;
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
      BusyE     = 1'b0;
      if (!reset) begin
         StallF    = lw_stall | mc_stall;
         StallD    = lw_stall | mc_stall;
         StallE    = mc_stall;
         FlushD    = PCSrcE;
         // A held Execute must not be cleared, so mcStall masks the load-use bubble.
         FlushE    = PCSrcE | (lw_stall & ~mc_stall);
         FlushM    = mc_stall;
         ForwardAE = fwd_sel(Rs1E);
         ForwardBE = fwd_sel(Rs2E);
         BusyE     = (state == BUSY);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (MC_EN && MultiCycleE) begin
                  state <= BUSY;
                  cnt   <= CNT_LOAD;
               end
            end
            BUSY: begin
               if (cnt != '0)
                  cnt <= cnt - 1'b1;
               else
                  state <= IDLE;
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

`ifdef HAZ_PERF_CNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         LwStallCnt <= '0;
         McStallCnt <= '0;
         FlushCnt   <= '0;
      end else begin
         if (lw_stall) LwStallCnt <= LwStallCnt + 32'd1;
         if (mc_stall) McStallCnt <= McStallCnt + 32'd1;
         if (PCSrcE)   FlushCnt   <= FlushCnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Testbench for hazard_controller: directed steps followed by randomized
// stimulus, checked against a cycle-level reference model of the spec.
module tb_hazard_controller;

   localparam int LAT = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic       MemReadE, RegWriteM, RegWriteW, PCSrcE, MultiCycleE;

   logic       StallF, StallD, StallE, FlushD, FlushE, FlushM, BusyE;
   logic [1:0] ForwardAE, ForwardBE;

   logic       StallF_1, StallD_1, StallE_1, FlushD_1, FlushE_1, FlushM_1, BusyE_1;
   logic [1:0] ForwardAE_1, ForwardBE_1;

`ifdef HAZ_PERF_CNT_EN
   logic [31:0] LwStallCnt, McStallCnt, FlushCnt;
   logic [31:0] LwStallCnt_1, McStallCnt_1, FlushCnt_1;
`endif

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: whether a multi-cycle op is resident in Execute and how
   // many cycles (1-based) it has been there.
   bit          m_active;
   int          m_age;
   logic [31:0] m_lw_cnt, m_mc_cnt, m_fl_cnt;

   always #5 clk = ~clk;

   hazard_controller #(.MC_LATENCY(LAT), .CNT_W(4)) u_dut (
      .clk(clk), .reset(reset),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
      .RdE(RdE), .RdM(RdM), .RdW(RdW),
      .MemReadE(MemReadE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .PCSrcE(PCSrcE), .MultiCycleE(MultiCycleE),
      .StallF(StallF), .StallD(StallD), .StallE(StallE),
      .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .BusyE(BusyE)
`ifdef HAZ_PERF_CNT_EN
      , .LwStallCnt(LwStallCnt), .McStallCnt(McStallCnt), .FlushCnt(FlushCnt)
`endif
   );

   hazard_controller #(.MC_LATENCY(1), .CNT_W(4)) u_lat1 (
      .clk(clk), .reset(reset),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
      .RdE(RdE), .RdM(RdM), .RdW(RdW),
      .MemReadE(MemReadE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .PCSrcE(PCSrcE), .MultiCycleE(MultiCycleE),
      .StallF(StallF_1), .StallD(StallD_1), .StallE(StallE_1),
      .FlushD(FlushD_1), .FlushE(FlushE_1), .FlushM(FlushM_1),
      .ForwardAE(ForwardAE_1), .ForwardBE(ForwardBE_1), .BusyE(BusyE_1)
`ifdef HAZ_PERF_CNT_EN
      , .LwStallCnt(LwStallCnt_1), .McStallCnt(McStallCnt_1), .FlushCnt(FlushCnt_1)
`endif
   );

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

`ifdef HAZ_PERF_CNT_EN
   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask
`endif

   function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
      if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
      if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic ref_lw();
      return MemReadE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
   endfunction

   function automatic logic ref_mc(input int lat);
      if (lat < 2) return 1'b0;
      if (m_active) return (m_age < lat);
      return MultiCycleE;
   endfunction

   task automatic model_reset();
      m_active = 0;
      m_age    = 0;
      m_lw_cnt = '0;
      m_mc_cnt = '0;
      m_fl_cnt = '0;
   endtask

   // Called 1 time unit after a rising edge; samples away from the edge.
   task automatic check_all(input string tag);
      logic lw, mc, lw1;
      #3;
      lw  = ref_lw() & ~reset;
      mc  = ref_mc(LAT) & ~reset;
      lw1 = lw;
      chk1({tag, "/StallF"}, StallF, lw | mc);
      chk1({tag, "/StallD"}, StallD, lw | mc);
      chk1({tag, "/StallE"}, StallE, mc);
      chk1({tag, "/FlushD"}, FlushD, PCSrcE & ~reset);
      chk1({tag, "/FlushE"}, FlushE, (PCSrcE & ~reset) | (lw & ~mc));
      chk1({tag, "/FlushM"}, FlushM, mc);
      chk2({tag, "/FwdA"}, ForwardAE, reset ? 2'b00 : ref_fwd(Rs1E));
      chk2({tag, "/FwdB"}, ForwardBE, reset ? 2'b00 : ref_fwd(Rs2E));
      chk1({tag, "/BusyE"}, BusyE, m_active & ~reset);
      chk1({tag, "/L1_StallF"}, StallF_1, lw1);
      chk1({tag, "/L1_StallE"}, StallE_1, 1'b0);
      chk1({tag, "/L1_FlushE"}, FlushE_1, (PCSrcE & ~reset) | lw1);
      chk1({tag, "/L1_BusyE"}, BusyE_1, 1'b0);
`ifdef HAZ_PERF_CNT_EN
      chk32({tag, "/LwCnt"}, LwStallCnt, m_lw_cnt);
      chk32({tag, "/McCnt"}, McStallCnt, m_mc_cnt);
      chk32({tag, "/FlCnt"}, FlushCnt, m_fl_cnt);
`endif
   endtask

   task automatic advance();
      logic lw, mc;
      lw = ref_lw();
      mc = ref_mc(LAT);
      @(posedge clk);
      if (reset) begin
         model_reset();
      end else begin
         if (lw)     m_lw_cnt = m_lw_cnt + 1;
         if (mc)     m_mc_cnt = m_mc_cnt + 1;
         if (PCSrcE) m_fl_cnt = m_fl_cnt + 1;
         if (m_active) begin
            if (m_age >= LAT) m_active = 0;
            else m_age++;
         end else if (MultiCycleE && LAT >= 2) begin
            m_active = 1;
            m_age    = 2;
         end
      end
      #1;
   endtask

   task automatic idle_inputs();
      Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0;
      RdE = 0; RdM = 0; RdW = 0;
      MemReadE = 0; RegWriteM = 0; RegWriteW = 0;
      PCSrcE = 0; MultiCycleE = 0;
   endtask

   initial begin
      logic [0:7] pat_stall;
      logic [0:7] pat_busy;
      pat_stall = 8'b1110_1110;
      pat_busy  = 8'b0111_0111;
      model_reset();

      // Reset with hazardous inputs present: everything must be quiet.
      reset = 1'b1;
      idle_inputs();
      MemReadE = 1; RdE = 3; Rs1D = 3; PCSrcE = 1; MultiCycleE = 1;
      RegWriteM = 1; RdM = 4; Rs1E = 4;
      check_all("reset");
      advance();
      check_all("reset2");
      advance();
      reset = 1'b0;
      idle_inputs();
      check_all("idle");
      advance();

      // Forwarding priority and x0 suppression.
      RegWriteM = 1; RdM = 5; RegWriteW = 1; RdW = 5; Rs1E = 5; Rs2E = 0;
      check_all("fwd_M");
      chk2("fwd_M_A", ForwardAE, 2'b10);
      chk2("fwd_M_B", ForwardBE, 2'b00);
      advance();
      RegWriteM = 0;
      check_all("fwd_W");
      chk2("fwd_W_A", ForwardAE, 2'b01);
      advance();
      RegWriteM = 1; RdM = 0; RdW = 0; Rs1E = 0; Rs2E = 0;
      check_all("fwd_x0");
      chk2("fwd_x0_A", ForwardAE, 2'b00);
      advance();
      idle_inputs();

      // Load-use.
      MemReadE = 1; RdE = 7; Rs2D = 7;
      check_all("lw");
      chk1("lw_StallF", StallF, 1'b1);
      chk1("lw_FlushE", FlushE, 1'b1);
      chk1("lw_StallE", StallE, 1'b0);
      advance();
      RdE = 0; Rs2D = 0;
      check_all("lw_x0");
      chk1("lw_x0_StallF", StallF, 1'b0);
      advance();
      idle_inputs();

      // Branch flush.
      PCSrcE = 1;
      check_all("br");
      chk1("br_FlushD", FlushD, 1'b1);
      chk1("br_FlushE", FlushE, 1'b1);
      chk1("br_StallF", StallF, 1'b0);
      advance();
      PCSrcE = 0;
      check_all("br_after");
      advance();

      // Two back-to-back multi-cycle ops.
      MultiCycleE = 1;
      for (int i = 0; i < 8; i++) begin
         check_all("mc");
         chk1("mc_pat_StallE", StallE, pat_stall[i]);
         chk1("mc_pat_FlushM", FlushM, pat_stall[i]);
         chk1("mc_pat_BusyE", BusyE, pat_busy[i]);
         advance();
      end
      MultiCycleE = 0;
      check_all("mc_done");
      advance();

      // Asynchronous reset in the 2nd stall cycle.
      MultiCycleE = 1;
      check_all("mcr_1");
      advance();
      #2;
      chk1("mcr_pre_StallE", StallE, 1'b1);
      chk1("mcr_pre_BusyE", BusyE, 1'b1);
      reset = 1'b1;
      #1;
      chk1("mcr_async_StallE", StallE, 1'b0);
      chk1("mcr_async_StallF", StallF, 1'b0);
      chk1("mcr_async_FlushM", FlushM, 1'b0);
      chk1("mcr_async_BusyE", BusyE, 1'b0);
      // Realign to the usual sampling point one unit after the next edge.
      @(posedge clk);
      model_reset();
      #1;
      MultiCycleE = 0;
      check_all("mcr_hold");
      advance();
      reset = 1'b0;
      check_all("mcr_idle");
      chk1("mcr_idle_BusyE", BusyE, 1'b0);
      advance();
      MultiCycleE = 1;
      check_all("mcr_restart");
      chk1("mcr_restart_StallE", StallE, 1'b1);
      advance();
      MultiCycleE = 0;

      // Randomized traffic.
      for (int n = 0; n < 400; n++) begin
         Rs1D = 5'($urandom_range(0, 3));
         Rs2D = 5'($urandom_range(0, 3));
         Rs1E = 5'($urandom_range(0, 3));
         Rs2E = 5'($urandom_range(0, 3));
         RdE  = 5'($urandom_range(0, 3));
         RdM  = 5'($urandom_range(0, 3));
         RdW  = 5'($urandom_range(0, 3));
         MemReadE    = ($urandom_range(0, 3) == 0);
         RegWriteM   = ($urandom_range(0, 1) == 0);
         RegWriteW   = ($urandom_range(0, 1) == 0);
         PCSrcE      = ($urandom_range(0, 7) == 0);
         MultiCycleE = ($urandom_range(0, 3) == 0);
         reset       = ($urandom_range(0, 99) == 0);
         check_all("rnd");
         advance();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Pipeline hazard and sequencing controller for the 5-stage core.
- Drives stall/flush for the F/D, D/E and E/M stage registers. The IF/ID register's enable is ~StallD and its flush is FlushD.
- Generates operand forwarding selects for Execute.
- Contains a counter-based FSM that holds Execute for multi-cycle ops (mul/div) and inserts bubbles into Memory.

Parameters:
MC_LATENCY, 4, total cycles a multi-cycle op occupies Execute (legal 1..16)
CNT_W, 4, width of the multi-cycle down-counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
Rs1D  in  5  source reg 1 of instr in Decode
Rs2D  in  5  source reg 2 of instr in Decode
Rs1E  in  5  source reg 1 of instr in Execute
Rs2E  in  5  source reg 2 of instr in Execute
RdE  in  5  dest reg in Execute
RdM  in  5  dest reg in Memory
RdW  in  5  dest reg in Writeback
MemReadE  in  1  load in Execute
RegWriteM  in  1  Memory-stage instr writes RF
RegWriteW  in  1  Writeback-stage instr writes RF
PCSrcE  in  1  taken branch/jump resolved in Execute
MultiCycleE  in  1  multi-cycle op in Execute
StallF  out  1  hold PC
StallD  out  1  hold IF/ID register
StallE  out  1  hold ID/EX register
FlushD  out  1  clear IF/ID register
FlushE  out  1  clear ID/EX register
FlushM  out  1  clear EX/MEM register (bubble)
ForwardAE  out  2  operand A select: 00 RF, 01 ResultW, 10 ALUResultM
ForwardBE  out  2  operand B select, same encoding
BusyE  out  1  multi-cycle FSM not IDLE

Behaviour:
Reset:
- Asynchronous reset sets state to IDLE and the counter to 0.
- While reset is high, all stall/flush outputs are 0, ForwardAE/BE are 00 and BusyE is 0.

Forwarding (combinational):
- ForwardAE = 10 if RegWriteM && RdM!=0 && RdM==Rs1E.
- Otherwise 01 if RegWriteW && RdW!=0 && RdW==Rs1E.
- Otherwise 00.
- M has priority over W. ForwardBE is the same using Rs2E.

Load-use:
- lwStall = MemReadE && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).

Multi-cycle FSM, states IDLE and BUSY:
- IDLE, MultiCycleE=1, MC_LATENCY>=2:
  - mcStall=1 this cycle.
  - Next state BUSY, counter loaded with MC_LATENCY-2.
- BUSY, counter!=0: mcStall=1, counter decrements.
- BUSY, counter==0: mcStall=0 (release cycle), next state IDLE. The op leaves Execute on the following edge.
- Because the release cycle is BUSY, the same op never retriggers. Back-to-back multi-cycle ops restart from IDLE on the next cycle.
- Total stall cycles per op = MC_LATENCY-1.
- MC_LATENCY=1: FSM stays IDLE, mcStall is never asserted.

Outputs:
- StallF = lwStall | mcStall
- StallD = lwStall | mcStall
- StallE = mcStall
- FlushD = PCSrcE
- FlushE = PCSrcE | (lwStall & ~mcStall)
- FlushM = mcStall
- BusyE = (state==BUSY)

Simultaneous events:
- MemReadE and MultiCycleE both high: illegal (decoder guarantees exclusivity). The controller gives mcStall priority and does not flush E.
- PCSrcE and MultiCycleE both high: illegal; PCSrcE flushes are still driven.
- Reset during BUSY: immediate return to IDLE, stalls drop asynchronously.

Optional Feature:
Macro HAZ_PERF_CNT_EN.
- Defined:
  - Adds outputs LwStallCnt[31:0], McStallCnt[31:0] and FlushCnt[31:0].
  - Each counts clock cycles with lwStall, mcStall or PCSrcE high respectively.
  - Counters wrap at 2^32 and reset to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Forwarding: RegWriteM=1, RdM=5; RegWriteW=1, RdW=5; Rs1E=5, Rs2E=0 -> ForwardAE=10, ForwardBE=00. Drop RegWriteM -> ForwardAE=01. RdM=RdW=0 with matching Rs -> 00.
- Load-use: MemReadE=1, RdE=7, Rs2D=7 for one cycle -> StallF=StallD=1, FlushE=1, StallE=0. RdE=0 -> no stall.
- Branch: PCSrcE=1 for one cycle -> FlushD=FlushE=1, no stalls. With HAZ_PERF_CNT_EN, FlushCnt increments by 1.
- Multi-cycle, MC_LATENCY=4, MultiCycleE held high until release:
  - StallF/D/E=1 and FlushM=1 for exactly 3 cycles, then 0 in the release cycle.
  - BusyE high for cycles 2-4.
  - A second op on the next cycle stalls again for 3 cycles.
- Reset mid-BUSY: assert reset asynchronously in the 2nd stall cycle -> stalls and BusyE drop to 0 without a clock edge. After deassert with MultiCycleE=0, the FSM is IDLE.
- MC_LATENCY=1 build: MultiCycleE=1 -> no stall, BusyE stays 0.
